// File: rtl/pixel_stream_framer.sv
// Raster tagger: stamps each accepted RGB pixel with x/y and sof/eol/eof and
// forwards it through a registered 2-entry skid buffer with full backpressure.
module pixel_stream_framer #(
  parameter int COORD_WIDTH  = 16,
  parameter int RGB_SIZE     = 24,
  parameter int MAX_WIDTH    = 640,
  parameter int MAX_HEIGHT   = 480,
  parameter int Y_DESCEND    = 1,
  parameter int FCOUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [COORD_WIDTH-1:0]  cfg_width,
  input  logic [COORD_WIDTH-1:0]  cfg_height,
  input  logic                    frame_abort,
  input  logic [RGB_SIZE-1:0]     in_colour,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [RGB_SIZE-1:0]     out_colour,
  output logic [COORD_WIDTH-1:0]  out_x,
  output logic [COORD_WIDTH-1:0]  out_y,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FCOUNT_WIDTH-1:0] frame_count,
  output logic                    in_frame
);

  typedef struct packed {
    logic [RGB_SIZE-1:0]    colour;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic                   sof;
    logic                   eol;
    logic                   eof;
  } beat_t;

  localparam logic [COORD_WIDTH-1:0] MAX_W = COORD_WIDTH'(MAX_WIDTH);
  localparam logic [COORD_WIDTH-1:0] MAX_H = COORD_WIDTH'(MAX_HEIGHT);

  function automatic logic [COORD_WIDTH-1:0] clamp_dim(
    input logic [COORD_WIDTH-1:0] v,
    input logic [COORD_WIDTH-1:0] maxv
  );
    return ((v == '0) || (v > maxv)) ? maxv : v;
  endfunction

  // Raster state
  logic [COORD_WIDTH-1:0]  x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic                    at_start_q, at_start_d;
  logic                    in_frame_q, in_frame_d;
  logic [FCOUNT_WIDTH-1:0] fc_q, fc_d;

  // Handshake state
  beat_t out_q, out_d, skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q;

  logic                   accept, load_out, sof, eol, eof;
  logic [COORD_WIDTH-1:0] w_eff, h_eff, tag_x, tag_y, start_row, end_row;
  beat_t                  new_beat;

  always_comb begin
    accept    = in_valid & in_ready_q;
    // Abort makes the current pixel the first of a fresh frame.
    sof       = at_start_q | frame_abort;
    w_eff     = sof ? clamp_dim(cfg_width, MAX_W)  : w_q;
    h_eff     = sof ? clamp_dim(cfg_height, MAX_H) : h_q;
    start_row = (Y_DESCEND != 0) ? h_eff - 1'b1 : '0;
    end_row   = (Y_DESCEND != 0) ? '0 : h_eff - 1'b1;
    tag_x     = sof ? '0 : x_q;
    tag_y     = sof ? start_row : y_q;
    eol       = (tag_x == w_eff - 1'b1);
    eof       = eol && (tag_y == end_row);
    new_beat  = '{colour: in_colour, x: tag_x, y: tag_y, sof: sof, eol: eol, eof: eof};
  end

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    at_start_d = at_start_q;
    in_frame_d = in_frame_q;
    fc_d       = fc_q;
    if (accept) begin
      w_d        = w_eff;
      h_d        = h_eff;
      y_d        = tag_y;
      at_start_d = 1'b0;
      in_frame_d = 1'b1;
      if (eof) begin
        x_d        = '0;
        at_start_d = 1'b1;
        in_frame_d = 1'b0;
        fc_d       = fc_q + 1'b1;
      end else if (eol) begin
        x_d = '0;
        y_d = (Y_DESCEND != 0) ? tag_y - 1'b1 : tag_y + 1'b1;
      end else begin
        x_d = tag_x + 1'b1;
      end
    end else if (frame_abort) begin
      x_d        = '0;
      at_start_d = 1'b1;
      in_frame_d = 1'b0;
    end
  end

  always_comb begin
    load_out     = !out_valid_q | out_ready;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (load_out) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = new_beat;
      end
    end else if (accept) begin
      // Output register is stalled: park the beat in the skid slot.
      skid_d       = new_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= MAX_W;
      h_q          <= MAX_H;
      at_start_q   <= 1'b1;
      in_frame_q   <= 1'b0;
      fc_q         <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      at_start_q   <= at_start_d;
      in_frame_q   <= in_frame_d;
      fc_q         <= fc_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_colour  = out_q.colour;
  assign out_x       = out_q.x;
  assign out_y       = out_q.y;
  assign out_sof     = out_q.sof;
  assign out_eol     = out_q.eol;
  assign out_eof     = out_q.eof;
  assign out_valid   = out_valid_q;
  assign frame_count = fc_q;
  assign in_frame    = in_frame_q;

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Scoreboard bench for pixel_stream_framer: a raster-index model predicts each
// tagged beat at input acceptance; beats are compared as the DUT hands them off.
module tb_pixel_stream_framer;
  localparam int CW  = 16;
  localparam int RGB = 24;
  localparam int MW  = 16;
  localparam int MH  = 8;
  localparam int FCW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [CW-1:0]  cfg_width = '0, cfg_height = '0;
  logic           frame_abort = 1'b0;
  logic [RGB-1:0] in_colour = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [RGB-1:0] out_colour;
  logic [CW-1:0]  out_x, out_y;
  logic           out_sof, out_eol, out_eof, out_valid;
  logic           out_ready = 1'b0;
  logic [FCW-1:0] frame_count;
  logic           in_frame;

  pixel_stream_framer #(
    .COORD_WIDTH(CW), .RGB_SIZE(RGB), .MAX_WIDTH(MW), .MAX_HEIGHT(MH),
    .Y_DESCEND(1), .FCOUNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .frame_abort(frame_abort), .in_colour(in_colour), .in_valid(in_valid),
    .in_ready(in_ready), .out_colour(out_colour), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .out_valid(out_valid),
    .out_ready(out_ready), .frame_count(frame_count), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RGB-1:0] col;
    logic [34:0]    tag;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   n_acc = 0, n_cons = 0;
  int   m_idx = 0, m_w = MW, m_h = MH, m_fc = 0;
  bit   m_inframe = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int clampd(input int v, input int maxv);
    return (v == 0 || v > maxv) ? maxv : v;
  endfunction

  task automatic model_accept(input bit abort);
    int x, row, y;
    bit sof, eol, eof;
    exp_t e;
    if (m_idx == 0 || abort) begin
      m_idx = 0;
      m_w   = clampd(int'(cfg_width), MW);
      m_h   = clampd(int'(cfg_height), MH);
    end
    x   = m_idx % m_w;
    row = m_idx / m_w;
    y   = m_h - 1 - row;
    sof = (m_idx == 0);
    eol = (x == m_w - 1);
    eof = (m_idx == m_w * m_h - 1);
    e.col = in_colour;
    e.tag = {CW'(x), CW'(y), sof, eol, eof};
    q.push_back(e);
    n_acc++;
    if (eof) begin
      m_idx     = 0;
      m_fc      = (m_fc + 1) % (1 << FCW);
      m_inframe = 1'b0;
    end else begin
      m_idx++;
      m_inframe = 1'b1;
    end
  endtask

  task automatic consume();
    exp_t e;
    if (q.size() == 0) begin
      chk("sb_underflow", 64'(q.size()), 64'd1);
    end else begin
      e = q.pop_front();
      chk("colour", 64'(out_colour), 64'(e.col));
      chk("tag_xy_sof_eol_eof", 64'({out_x, out_y, out_sof, out_eol, out_eof}), 64'(e.tag));
      n_cons++;
    end
  endtask

  // Drive one cycle's inputs and account for the handshakes at the coming edge.
  task automatic step(input bit v, input bit rdy, input bit abort);
    @(negedge clk);
    in_valid    = v;
    out_ready   = rdy;
    frame_abort = abort;
    in_colour   = RGB'($urandom);
    if (out_valid && out_ready) consume();
    if (in_valid && in_ready) model_accept(abort);
    else if (abort) begin
      m_idx     = 0;
      m_inframe = 1'b0;
    end
  endtask

  task automatic run_beats(input int n, input bit toggle);
    int t = 0;
    int start = n_acc;
    while ((n_acc - start) < n && t < 4000) begin
      step(1'b1, toggle ? (t % 2 == 0) : 1'b1, 1'b0);
      t++;
    end
    chk("run_timeout", 64'(n_acc - start), 64'(n));
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 100) begin
      step(1'b0, 1'b1, 1'b0);
      t++;
    end
    @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'd0);
    chk("frame_count", 64'(frame_count), 64'(m_fc));
    chk("in_frame", 64'(in_frame), 64'(m_inframe));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_flags", 64'({out_sof, out_eol, out_eof, in_frame}), 64'd0);
    chk("rst_data", 64'({out_colour, out_x, out_y, frame_count}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    // 4x3 frame, streaming at full rate
    cfg_width = 16'd4; cfg_height = 16'd3;
    n_cons = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    chk("stream_accepts", 64'(n_acc), 64'd12);
    chk("stream_latency", 64'(n_cons), 64'd11);
    drain();

    // 4x3 frame with out_ready toggling
    run_beats(12, 1'b1);
    drain();

    // Skid fill: two beats absorbed with the output stalled, then in_ready drops
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("in_ready_full", 64'(in_ready), 64'd0);
    chk("out_valid_stalled", 64'(out_valid), 64'd1);
    step(1'b0, 1'b1, 1'b1);
    drain();

    // Clamped size: width 0 -> MW, height above MH -> MH
    cfg_width = 16'd0; cfg_height = 16'd200;
    run_beats(MW * MH, 1'b0);
    drain();

    // Abort together with an accept on pixel 5 of a 4x3 frame
    cfg_width = 16'd4; cfg_height = 16'd3;
    run_beats(4, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    run_beats(11, 1'b0);
    drain();

    // 1x1 frames: every beat is sof/eol/eof, frame_count wraps
    cfg_width = 16'd1; cfg_height = 16'd1;
    run_beats(20, 1'b0);
    drain();

    // Asynchronous reset while a beat is pending
    cfg_width = 16'd4; cfg_height = 16'd3;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_cleared", 64'({out_x, out_y, frame_count, in_frame, in_ready}), 64'd0);
    #4 reset_n = 1'b1;
    q.delete();
    m_idx = 0; m_fc = 0; m_inframe = 1'b0;
    run_beats(12, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
